// File: rtl/memory_io_controller.sv
// CPU memory/MMIO controller: one request becomes a wait-stated SRAM access
// or an access to LC-3 style status/data register pairs of input/output devices.
module memory_io_controller #(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 16,
    parameter int                WAIT_STATES = 1,
    parameter int                NUM_IN      = 1,
    parameter int                NUM_OUT     = 1,
    parameter logic [ADDR_W-1:0] MMIO_BASE   = 16'hFE00
) (
    input  logic                      Clk,
    input  logic                      Reset_N,
    input  logic                      Req,
    input  logic                      R_W,
    input  logic [ADDR_W-1:0]         Addr,
    input  logic [DATA_W-1:0]         WData,
    output logic [DATA_W-1:0]         RData,
    output logic                      Ack,
    output logic                      Mem_CE,
    output logic                      Mem_OE,
    output logic                      Mem_WE,
    output logic                      Mem_LB,
    output logic                      Mem_UB,
    output logic [ADDR_W-1:0]         Mem_Addr,
    output logic [DATA_W-1:0]         Mem_WData,
    input  logic [DATA_W-1:0]         Mem_RData,
    input  logic [NUM_IN-1:0]         In_Valid,
    input  logic [NUM_IN*DATA_W-1:0]  In_Data,
    output logic [NUM_OUT-1:0]        Out_Valid,
    output logic [NUM_OUT*DATA_W-1:0] Out_Data,
    input  logic [NUM_OUT-1:0]        Out_Ready
);

    typedef enum logic [2:0] {S_IDLE, S_SRAM, S_OUTWAIT, S_ACK, S_DONE} state_t;

    localparam logic [ADDR_W-3:0] LP_NUM_IN  = (ADDR_W-2)'(NUM_IN);
    localparam logic [ADDR_W-3:0] LP_DEV_END = (ADDR_W-2)'(NUM_IN + NUM_OUT);

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_cnt;
    logic                r_ack, r_ce, r_oe, r_we;
    logic [DATA_W-1:0]   r_rdata, r_mem_wdata;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_in_data [NUM_IN];
    logic [NUM_IN-1:0]   r_in_flag, r_in_ovr;
    logic [DATA_W-1:0]   r_out_data [NUM_OUT];
    logic [NUM_OUT-1:0]  r_out_valid;

    logic [ADDR_W-1:0]   w_off;
    logic [ADDR_W-3:0]   w_dev;
    logic                w_is_mmio, w_is_stat, w_is_data, w_in_hit, w_out_hit;
    logic [1:0]          w_in_idx, w_out_idx;
    logic [DATA_W-1:0]   w_rd_val;
    logic                w_out_busy;
    logic                w_sram_start, w_sram_done, w_mmio_rd, w_out_load;

    assign w_is_mmio = (Addr >= MMIO_BASE);
    assign w_off     = Addr - MMIO_BASE;
    assign w_dev     = w_off[ADDR_W-1:2];
    assign w_is_stat = (w_off[1:0] == 2'd0);
    assign w_is_data = (w_off[1:0] == 2'd2);
    assign w_in_hit  = w_is_mmio && (w_dev < LP_NUM_IN);
    assign w_out_hit = w_is_mmio && !w_in_hit && (w_dev < LP_DEV_END);
    assign w_in_idx  = w_dev[1:0];
    assign w_out_idx = 2'(w_dev - LP_NUM_IN);

    always_comb begin
        w_rd_val   = '0;
        w_out_busy = 1'b0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (w_in_hit && w_in_idx == 2'(i)) begin
                if (w_is_stat) begin
                    w_rd_val[15] = r_in_flag[i];
                    w_rd_val[14] = r_in_ovr[i];
                end else if (w_is_data) begin
                    w_rd_val = r_in_data[i];
                end
            end
        end
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            if (w_out_hit && w_out_idx == 2'(j)) begin
                w_out_busy = r_out_valid[j];
                if (w_is_stat)      w_rd_val[15] = ~r_out_valid[j];
                else if (w_is_data) w_rd_val     = r_out_data[j];
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sram_start = 1'b0;
        w_sram_done  = 1'b0;
        w_mmio_rd    = 1'b0;
        w_out_load   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Req) begin
                    if (!w_is_mmio) begin
                        w_state_nxt  = S_SRAM;
                        w_sram_start = 1'b1;
                    end else if (R_W && w_out_hit && w_is_data && w_out_busy) begin
                        w_state_nxt = S_OUTWAIT;
                    end else begin
                        w_state_nxt = S_ACK;
                        w_mmio_rd   = !R_W;
                        w_out_load  = R_W && w_out_hit && w_is_data;
                    end
                end
            end
            S_SRAM: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_ACK;
                    w_sram_done = 1'b1;
                end
            end
            S_OUTWAIT: begin
                if (!w_out_busy) begin
                    w_state_nxt = S_ACK;
                    w_out_load  = 1'b1;
                end
            end
            S_ACK:   w_state_nxt = S_DONE;
            S_DONE:  if (!Req) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_ack       <= 1'b0;
            r_ce        <= 1'b0;
            r_oe        <= 1'b0;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_in_flag   <= '0;
            r_in_ovr    <= '0;
            r_out_valid <= '0;
            for (int unsigned i = 0; i < NUM_IN; i++)  r_in_data[i]  <= '0;
            for (int unsigned j = 0; j < NUM_OUT; j++) r_out_data[j] <= '0;
        end else begin
            r_ack <= (w_state_nxt == S_ACK);
            if (w_sram_start) begin
                r_cnt       <= 4'(WAIT_STATES);
                r_ce        <= 1'b1;
                r_oe        <= !R_W;
                r_we        <= R_W;
                r_mem_addr  <= Addr;
                r_mem_wdata <= WData;
            end else if (r_state == S_SRAM && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_sram_done) begin
                r_ce    <= 1'b0;
                r_oe    <= 1'b0;
                r_we    <= 1'b0;
                r_rdata <= Mem_RData;
            end
            if (w_mmio_rd) r_rdata <= w_rd_val;
            // A capture in the same cycle as a register read overrides the read's clear.
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (w_mmio_rd && w_in_hit && w_in_idx == 2'(i) && w_is_stat) r_in_ovr[i] <= 1'b0;
                if (In_Valid[i]) begin
                    r_in_data[i] <= In_Data[i*DATA_W +: DATA_W];
                    r_in_flag[i] <= 1'b1;
                    if (r_in_flag[i]) r_in_ovr[i] <= 1'b1;
                end else if (w_mmio_rd && w_in_hit && w_in_idx == 2'(i) && w_is_data) begin
                    r_in_flag[i] <= 1'b0;
                end
            end
            for (int unsigned j = 0; j < NUM_OUT; j++) begin
                if (w_out_load && w_out_idx == 2'(j)) begin
                    r_out_valid[j] <= 1'b1;
                    r_out_data[j]  <= WData;
                end else if (r_out_valid[j] && Out_Ready[j]) begin
                    r_out_valid[j] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        Out_Data = '0;
        for (int unsigned j = 0; j < NUM_OUT; j++) Out_Data[j*DATA_W +: DATA_W] = r_out_data[j];
    end

    assign Ack       = r_ack;
    assign RData     = r_rdata;
    assign Mem_CE    = r_ce;
    assign Mem_LB    = r_ce;
    assign Mem_UB    = r_ce;
    assign Mem_OE    = r_oe;
    assign Mem_WE    = r_we;
    assign Mem_Addr  = r_mem_addr;
    assign Mem_WData = r_mem_wdata;
    assign Out_Valid = r_out_valid;

endmodule

// File: tb/tb_memory_io_controller.sv
// Scoreboard bench for memory_io_controller: stimulus pushes expected responses,
// a negedge monitor checks every Ack and every output-device transfer.
module tb_memory_io_controller;

    localparam int WS      = 1;
    localparam int K_MMIO  = 0;
    localparam int K_SRAM  = 1;
    localparam int K_STALL = 2;

    logic        Clk = 1'b0;
    logic        Reset_N;
    logic        Req, R_W;
    logic [15:0] Addr, WData, RData, Mem_Addr, Mem_WData, Mem_RData;
    logic        Ack, Mem_CE, Mem_OE, Mem_WE, Mem_LB, Mem_UB;
    logic [0:0]  In_Valid, Out_Valid, Out_Ready;
    logic [15:0] In_Data, Out_Data;

    memory_io_controller #(
        .ADDR_W(16), .DATA_W(16), .WAIT_STATES(WS),
        .NUM_IN(1), .NUM_OUT(1), .MMIO_BASE(16'hFE00)
    ) dut (
        .Clk(Clk), .Reset_N(Reset_N), .Req(Req), .R_W(R_W), .Addr(Addr),
        .WData(WData), .RData(RData), .Ack(Ack),
        .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Mem_LB(Mem_LB), .Mem_UB(Mem_UB),
        .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData), .Mem_RData(Mem_RData),
        .In_Valid(In_Valid), .In_Data(In_Data),
        .Out_Valid(Out_Valid), .Out_Data(Out_Data), .Out_Ready(Out_Ready)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // External SRAM emulation, window 0x3000-0x30FF
    logic [15:0] ext [256];
    assign Mem_RData = (Mem_Addr[15:8] == 8'h30) ? ext[Mem_Addr[7:0]] : 16'hDEAD;
    always @(posedge Clk) begin
        if (!Reset_N) begin
            for (int i = 0; i < 256; i++) ext[i] <= 16'h0000;
        end else if (Mem_CE && Mem_WE && Mem_Addr[15:8] == 8'h30) begin
            ext[Mem_Addr[7:0]] <= Mem_WData;
        end
    end

    // Reference model
    logic [15:0] m_mem [256];
    logic        m_flag = 1'b0, m_ovr = 1'b0, m_pend = 1'b0;
    logic [15:0] m_data = 16'h0, m_last = 16'h0;
    logic [15:0] out_q [$];

    typedef struct {
        bit          chk_rd;
        logic [15:0] rd;
        int          lat;
        int          ce;
        int          we;
        int          oe;
    } exp_t;
    exp_t sbq [$];

    function automatic logic [15:0] model_read(input logic [15:0] a);
        int off, dev, r;
        logic [15:0] v;
        off = int'(a) - 'hFE00;
        dev = off / 4;
        r   = off % 4;
        v   = 16'h0000;
        if (dev == 0) begin
            if (r == 0) begin v = {m_flag, m_ovr, 14'b0}; m_ovr = 1'b0; end
            else if (r == 2) begin v = m_data; m_flag = 1'b0; end
        end else if (dev == 1) begin
            if (r == 0) v = {~m_pend, 15'b0};
            else if (r == 2) v = m_last;
        end
        return v;
    endfunction

    function automatic void model_write(input logic [15:0] a, input logic [15:0] d);
        if (a == 16'hFE06) begin
            m_last = d;
            m_pend = 1'b1;
            out_q.push_back(d);
        end
    endfunction

    function automatic void model_capture(input logic [15:0] d, input logic prior_flag);
        if (prior_flag) m_ovr = 1'b1;
        m_flag = 1'b1;
        m_data = d;
    endfunction

    // Monitor
    int   ack_count = 0;
    int   cyc = 0, n_ce = 0, n_we = 0, n_oe = 0;
    bit   prev_req = 0, prev_xfer = 0;
    exp_t mon_e;

    always @(negedge Clk) begin
        if (!Reset_N) begin
            prev_req  = 0;
            prev_xfer = 0;
        end else begin
            if (Req && !prev_req) begin cyc = 0; n_ce = 0; n_we = 0; n_oe = 0; end
            if (Req) begin
                if (Mem_CE && Mem_LB && Mem_UB) n_ce++;
                if (Mem_WE) n_we++;
                if (Mem_OE) n_oe++;
            end
            if (Ack) begin
                ack_count++;
                chk("ack_has_expect", 32'(sbq.size() > 0), 32'd1);
                if (sbq.size() > 0) begin
                    mon_e = sbq.pop_front();
                    if (mon_e.chk_rd) chk("rdata", 32'(RData), 32'(mon_e.rd));
                    if (mon_e.lat >= 0) chk("latency", cyc, mon_e.lat);
                    chk("ce_lb_ub_cycles", n_ce, mon_e.ce);
                    chk("we_cycles", n_we, mon_e.we);
                    chk("oe_cycles", n_oe, mon_e.oe);
                end
            end
            if (Req) cyc++;
            prev_req = Req;
            if (prev_xfer) chk("valid_gap", 32'(Out_Valid), 32'd0);
            prev_xfer = Out_Valid[0] && Out_Ready[0];
            if (prev_xfer) begin
                chk("out_has_expect", 32'(out_q.size() > 0), 32'd1);
                if (out_q.size() > 0) chk("out_word", 32'(Out_Data), 32'(out_q.pop_front()));
            end
        end
    end

    task automatic access(input bit rw, input logic [15:0] a, input logic [15:0] wd,
                          input int kind, input int hold, input bit pulse, input logic [15:0] pd);
        exp_t e;
        bit   got;
        logic f0;
        e = '{chk_rd: 0, rd: 16'h0, lat: -1, ce: 0, we: 0, oe: 0};
        f0 = m_flag;
        if (kind == K_SRAM) begin
            e.lat = WS + 2;
            e.ce  = WS + 1;
            e.we  = rw ? WS + 1 : 0;
            e.oe  = rw ? 0 : WS + 1;
            if (rw) m_mem[a[7:0]] = wd;
            else begin e.chk_rd = 1; e.rd = m_mem[a[7:0]]; end
        end else begin
            e.lat = (kind == K_MMIO) ? 1 : -1;
            if (rw) model_write(a, wd);
            else begin e.chk_rd = 1; e.rd = model_read(a); end
        end
        if (pulse) model_capture(pd, f0);
        sbq.push_back(e);
        @(posedge Clk); #1;
        Req = 1'b1; R_W = rw; Addr = a; WData = wd;
        if (pulse) begin In_Valid = 1'b1; In_Data = pd; end
        got = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge Clk);
            if (n == 1) In_Valid = 1'b0;
            if (Ack) begin got = 1; break; end
        end
        In_Valid = 1'b0;
        chk("ack_seen", 32'(got), 32'd1);
        if (!got && sbq.size() > 0) void'(sbq.pop_back());
        repeat (hold) @(negedge Clk);
        @(posedge Clk); #1;
        Req = 1'b0; R_W = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        access(1'b0, a, 16'h0, (a >= 16'hFE00) ? K_MMIO : K_SRAM, 0, 1'b0, 16'h0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        access(1'b1, a, d, (a >= 16'hFE00) ? K_MMIO : K_SRAM, 0, 1'b0, 16'h0);
    endtask

    task automatic pulse_in(input logic [15:0] d);
        @(posedge Clk); #1;
        In_Valid = 1'b1; In_Data = d;
        @(posedge Clk); #1;
        In_Valid = 1'b0;
        model_capture(d, m_flag);
    endtask

    task automatic drain();
        @(posedge Clk); #1 Out_Ready = 1'b1;
        @(posedge Clk); #1 Out_Ready = 1'b0;
        m_pend = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        bit got;
        logic [15:0] unm [8];
        unm = '{16'hFE01, 16'hFE03, 16'hFE05, 16'hFE07, 16'hFE08, 16'hFE0C, 16'hFFFE, 16'hFFFF};
        for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
        Reset_N = 1'b0; Req = 1'b0; R_W = 1'b0; Addr = 16'h0; WData = 16'h0;
        In_Valid = 1'b0; In_Data = 16'h0; Out_Ready = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_ack", 32'(Ack), 32'd0);
        chk("rst_rdata", 32'(RData), 32'd0);
        chk("rst_strobes", 32'({Mem_CE, Mem_OE, Mem_WE, Mem_LB, Mem_UB}), 32'd0);
        chk("rst_mem_addr_data", {Mem_Addr, Mem_WData}, 32'd0);
        chk("rst_out", 32'({Out_Valid, Out_Data}), 32'd0);
        @(negedge Clk) Reset_N = 1'b1;

        // Reset in the middle of an SRAM write
        @(posedge Clk); #1;
        Req = 1'b1; R_W = 1'b1; Addr = 16'h30FF; WData = 16'h1234;
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge Clk);
            if (Mem_WE) begin got = 1; break; end
        end
        chk("midwr_we_seen", 32'(got), 32'd1);
        #2 Reset_N = 1'b0;
        #1 chk("async_abort", 32'({Mem_CE, Mem_OE, Mem_WE, Mem_LB, Mem_UB, Ack}), 32'd0);
        Req = 1'b0; R_W = 1'b0;
        @(posedge Clk);
        @(negedge Clk) Reset_N = 1'b1;

        // SRAM write and read
        wr(16'h3000, 16'hBEEF);
        a0 = ack_count;
        access(1'b0, 16'h3000, 16'h0, K_SRAM, 5, 1'b0, 16'h0);
        chk("one_ack_per_req", ack_count - a0, 1);

        // Keyboard path
        pulse_in(16'h0041);
        rd(16'hFE00); rd(16'hFE02); rd(16'hFE00);

        // Overrun
        pulse_in(16'h0041);
        pulse_in(16'h0042);
        rd(16'hFE00); rd(16'hFE02); rd(16'hFE00);

        // Display path with stall
        wr(16'hFE06, 16'h0048);
        rd(16'hFE04);
        fork
            access(1'b1, 16'hFE06, 16'h0049, K_STALL, 0, 1'b0, 16'h0);
            begin
                int b0;
                b0 = ack_count;
                repeat (6) @(negedge Clk);
                chk("stall_no_ack", ack_count - b0, 0);
                chk("stall_data_held", 32'(Out_Data), 32'h0048);
                @(posedge Clk); #1 Out_Ready = 1'b1;
                @(posedge Clk); #1 Out_Ready = 1'b0;
            end
        join
        chk("out_data_2nd", 32'(Out_Data), 32'h0049);
        chk("out_valid_2nd", 32'(Out_Valid), 32'd1);
        rd(16'hFE06);
        drain();
        rd(16'hFE04);

        // Capture/read collision
        access(1'b0, 16'hFE02, 16'h0, K_MMIO, 0, 1'b1, 16'h0066);
        rd(16'hFE00);
        rd(16'hFE02);

        // Randomized traffic
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 9))
                0: wr(16'h3000 | 16'($urandom_range(0, 254)), 16'($urandom));
                1: rd(16'h3000 | 16'($urandom_range(0, 254)));
                2: pulse_in(16'($urandom));
                3: access(1'b0, 16'hFE00, 16'h0, K_MMIO, 0, $urandom_range(0, 3) == 0, 16'($urandom));
                4: access(1'b0, 16'hFE02, 16'h0, K_MMIO, 0, $urandom_range(0, 3) == 0, 16'($urandom));
                5: begin
                    if (m_pend) drain();
                    wr(16'hFE06, 16'($urandom));
                end
                6: rd(16'hFE04);
                7: rd(16'hFE06);
                8: access(1'($urandom_range(0, 1)), unm[$urandom_range(0, 7)], 16'($urandom),
                          K_MMIO, 0, 1'b0, 16'h0);
                default: begin
                    case ($urandom_range(0, 2))
                        0: wr(16'hFE00, 16'($urandom));
                        1: wr(16'hFE02, 16'($urandom));
                        default: wr(16'hFE04, 16'($urandom));
                    endcase
                end
            endcase
        end
        if (m_pend) drain();
        repeat (3) @(negedge Clk);
        chk("out_q_drained", out_q.size(), 0);
        chk("sb_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
